// File: rtl/tcb_arb_pkg.sv
// Shared types and helpers for the round-robin TCB arbiter (tcb_arb_rr).
package tcb_arb_pkg;

    // Tag index width is fixed wide enough for any practical manager count (up to 256).
    localparam int unsigned TAG_IDW = 8;

    typedef enum logic {
        ARB  = 1'b0,
        HOLD = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic               vld;
        logic [TAG_IDW-1:0] idx;
    } rsp_tag_t;

    function automatic int unsigned next_idx(input int unsigned g, input int unsigned n);
        return (g + 32'd1 == n) ? 32'd0 : g + 32'd1;
    endfunction

endpackage

// File: rtl/tcb_arb_rr_sel.sv
// Rotate-priority selector: first requesting index at or after ptr, wrapping modulo MPN.
module tcb_arb_rr_sel
    import tcb_arb_pkg::*;
#(
    parameter  int unsigned MPN = 2,
    localparam int unsigned IDW = $clog2(MPN)
)(
    input  logic [MPN-1:0] req_i,
    input  logic [IDW-1:0] ptr_i,
    output logic [IDW-1:0] gnt_o,
    output logic           any_o
);

    logic [IDW-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest requester wins last.
    always_comb begin
        gnt_o = ptr_i;
        idx   = '0;
        any_o = |req_i;
        for (int i = MPN - 1; i >= 0; i--) begin
            idx = IDW'((int'(ptr_i) + i) % MPN);
            if (req_i[idx]) gnt_o = idx;
        end
    end

endmodule

// File: rtl/tcb_arb_rr.sv
// Round-robin arbiter sharing one TCB subordinate among MPN managers, with response routing.
// Optional macro TCB_ARB_LOCK_EN adds man_lck_i for locked (atomic) transfer sequences.
module tcb_arb_rr
    import tcb_arb_pkg::*;
#(
    parameter  int unsigned MPN = 2,
    parameter  int unsigned ADR = 32,
    parameter  int unsigned DAT = 32,
    parameter  int unsigned DLY = 1,
    localparam int unsigned BEW = DAT / 8,
    localparam int unsigned IDW = $clog2(MPN)
)(
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [MPN-1:0]          man_vld_i,
    input  logic [MPN-1:0]          man_wen_i,
    input  logic [MPN-1:0][ADR-1:0] man_adr_i,
    input  logic [MPN-1:0][BEW-1:0] man_ben_i,
    input  logic [MPN-1:0][DAT-1:0] man_wdt_i,
`ifdef TCB_ARB_LOCK_EN
    input  logic [MPN-1:0]          man_lck_i,
`endif
    output logic [MPN-1:0]          man_rdy_o,
    output logic [MPN-1:0][DAT-1:0] man_rdt_o,
    output logic [MPN-1:0]          man_sts_o,
    output logic                    sub_vld_o,
    output logic                    sub_wen_o,
    output logic [ADR-1:0]          sub_adr_o,
    output logic [BEW-1:0]          sub_ben_o,
    output logic [DAT-1:0]          sub_wdt_o,
    input  logic                    sub_rdy_i,
    input  logic [DAT-1:0]          sub_rdt_i,
    input  logic                    sub_sts_i
);

    arb_state_t     state_q;
    logic [IDW-1:0] ptr_q, ptr_d, gnt_q, sel_gnt, gnt;
    logic           sel_any, own_vld, trn, lock;
    rsp_tag_t       tag_in, tag_out;

    tcb_arb_rr_sel #(.MPN(MPN)) u_sel (
        .req_i (man_vld_i),
        .ptr_i (ptr_q),
        .gnt_o (sel_gnt),
        .any_o (sel_any)
    );

    // A frozen grant only stands while its owner still requests; otherwise arbitrate afresh.
    assign own_vld   = (state_q == HOLD) && man_vld_i[gnt_q];
    assign gnt       = own_vld ? gnt_q : sel_gnt;

    assign sub_vld_o = sel_any & rst_ni;
    assign sub_wen_o = man_wen_i[gnt];
    assign sub_adr_o = man_adr_i[gnt];
    assign sub_ben_o = man_ben_i[gnt];
    assign sub_wdt_o = man_wdt_i[gnt];
    assign trn       = sub_vld_o & sub_rdy_i;
    assign ptr_d     = IDW'(next_idx(32'(gnt), MPN));

    always_comb begin
        man_rdy_o      = '0;
        man_rdy_o[gnt] = trn;
    end

`ifdef TCB_ARB_LOCK_EN
    assign lock = man_lck_i[gnt];
`else
    assign lock = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ARB;
            ptr_q   <= '0;
            gnt_q   <= '0;
        end else if (sub_vld_o) begin
            gnt_q <= gnt;
            if (!sub_rdy_i || lock) begin
                state_q <= HOLD;
            end else begin
                state_q <= ARB;
                ptr_q   <= ptr_d;
            end
        end else begin
            state_q <= ARB;
        end
    end

    assign tag_in = '{vld: trn, idx: TAG_IDW'(gnt)};

    generate
        if (DLY == 0) begin : g_comb
            assign tag_out = tag_in;
        end else begin : g_pipe
            rsp_tag_t pipe_q [DLY];
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    for (int d = 0; d < DLY; d++) pipe_q[d] <= '0;
                end else begin
                    pipe_q[0] <= tag_in;
                    for (int d = 1; d < DLY; d++) pipe_q[d] <= pipe_q[d-1];
                end
            end
            assign tag_out = pipe_q[DLY-1];
        end
    endgenerate

    always_comb begin
        man_rdt_o = '0;
        man_sts_o = '0;
        for (int i = 0; i < MPN; i++) begin
            if (tag_out.vld && tag_out.idx == TAG_IDW'(i)) begin
                man_rdt_o[i] = sub_rdt_i;
                man_sts_o[i] = sub_sts_i;
            end
        end
    end

endmodule
